store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write queue between the CPU data port and the L1 data cache write path. It accepts 32-bit stores from the CPU and acknowledges them without waiting for the cache. Stores are kept in order in a small FIFO and drained one per handshake into the cache's line-merge stage, as word-select, byte-align, byte-enable and data fields. It also flags any pending store to the same word as an incoming load, so the cache controller can stall that load until the store has drained.

## Interface
Parameters:
- DEPTH, 4: number of store entries; power of two, 2..16.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- mem_write  input  1  CPU store request; held until mem_resp.
- mem_address  input  32  CPU store byte address.
- mem_wdata  input  32  store data, already lane-positioned.
- mem_byte_enable  input  4  byte lanes written.
- mem_resp  output  1  one-cycle store acknowledge.
- drain_valid  output  1  head entry present.
- drain_address  output  32  head line address: {addr[31:5], 5'b0}.
- drain_sel  output  3  head word in line: addr[4:2].
- drain_align  output  2  head byte offset: addr[1:0].
- drain_byte_enable  output  4  head byte enables, as stored.
- drain_data  output  32  head data, as stored.
- drain_ack  input  1  cache has merged the head entry.
- load_check  input  1  cache is evaluating a load.
- load_address  input  32  load byte address.
- load_hazard  output  1  a pending store matches the load word.
- empty  output  1  no entries pending.
- full  output  1  count == DEPTH.

## Operation
- State: DEPTH entries of {addr[31:0], be[3:0], data[31:0], valid}, plus a head pointer, a tail pointer and a count (width clog2(DEPTH)+1).
- Push condition: mem_write && !mem_resp && !full.
  - If mem_byte_enable != 0: write {mem_address, mem_byte_enable, mem_wdata} at the tail, advance the tail, increment the count.
  - If mem_byte_enable == 0: nothing is enqueued, but mem_resp is still issued.
- Blocking: mem_resp high in a cycle blocks a push in that same cycle, so a request still held by the CPU is not accepted twice.
- Pop condition: drain_valid && drain_ack. Advance the head, decrement the count. drain_ack while empty is ignored.
- Push and pop in the same cycle: the count is unchanged and both pointers advance.
- Full blocks a push even when a pop occurs in that cycle; the push is accepted on the next cycle.
- Pointers wrap modulo DEPTH.
- Drain fields are taken combinationally from the head entry.
- Byte-enable patterns are not checked; the stored value is forwarded unchanged.
- load_hazard = load_check && (some valid entry has addr[31:2] == load_address[31:2]).
  - Byte enables are ignored in this comparison.
  - The head entry is included even while its pop is in progress.
  - An entry being pushed in the current cycle is not included.
- Reset (rst_n low at a rising edge):
  - count 0, both pointers 0, all valid bits 0, mem_resp 0.
  - Outputs after reset: drain_valid 0, load_hazard 0, empty 1, full 0.
  - Entry data/address are don't-care.
  - Reset mid-drain discards all pending stores.

## Timing
- mem_resp is registered: it is high exactly in the cycle after an accepting edge, for exactly one cycle.
- CPU store latency is 1 cycle when not full.
- Write-to-drain: an entry pushed at edge N into an empty buffer gives drain_valid high after edge N, i.e. it is visible the following cycle.
- drain_valid, the drain fields, empty and full are derived combinationally from registered state; there are no input-to-output paths through them.
- load_hazard is combinational from load_check, load_address and registered entries.
- Throughput: one push and one pop per cycle sustained, subject to mem_resp blocking (CPU side peaks at 1 store per 2 cycles).

## Test plan
- Reset, then store 0x0000_1044 / 0xDEAD_BEEF / be 1111 -> mem_resp one cycle later for one cycle; drain_valid=1, drain_address=0x0000_1040, drain_sel=001, drain_align=00, drain_data=0xDEAD_BEEF; drain_ack -> empty=1.
- Four stores with drain_ack held low -> full=1; a fifth store gets no mem_resp until one drain_ack; the fifth is then accepted and entries drain in push order.
- Pending store at 0x0000_2008 with be 0001; load_check with load_address 0x0000_200B -> load_hazard=1. With 0x0000_200C -> load_hazard=0.
- Store with be 0000 -> mem_resp pulses; count stays 0; drain_valid stays 0.
- Simultaneous push and pop at count 2 -> count stays 2; the pointer wrap past DEPTH-1 preserves order.
- Assert rst_n=0 for one cycle with 3 entries pending -> drain_valid=0, empty=1, mem_resp=0 on the next cycle.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write queue between the CPU store port and the L1
// data cache merge stage. Stores are acknowledged one cycle after acceptance,
// held in order, drained one per handshake, and checked against incoming
// loads so the cache can stall a load that hits a pending store word.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic        drain_valid,
  output logic [31:0] drain_address,
  output logic [2:0]  drain_sel,
  output logic [1:0]  drain_align,
  output logic [3:0]  drain_byte_enable,
  output logic [31:0] drain_data,
  input  logic        drain_ack,
  input  logic        load_check,
  input  logic [31:0] load_address,
  output logic        load_hazard,
  output logic        empty,
  output logic        full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage; contents need no reset because valid_reg gates every use.
  logic [31:0]      addr_mem [DEPTH];
  logic [3:0]       be_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             resp_reg;

  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      head_addr;
  logic [DEPTH-1:0] hit;

  // An outstanding acknowledge blocks acceptance so a request the CPU is
  // still holding is not taken twice. A zero byte-enable store is
  // acknowledged but never enqueued.
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);
  assign accept      = mem_write && !resp_reg && !full;
  assign push        = accept && (mem_byte_enable != 4'b0000);
  assign drain_valid = valid_reg[head_reg];
  assign pop         = drain_valid && drain_ack;
  assign mem_resp    = resp_reg;

  // Head entry is split into the fields the line-merge stage consumes.
  assign head_addr         = addr_mem[head_reg];
  assign drain_address     = {head_addr[31:5], 5'b0};
  assign drain_sel         = head_addr[4:2];
  assign drain_align       = head_addr[1:0];
  assign drain_byte_enable = be_mem[head_reg];
  assign drain_data        = data_mem[head_reg];

  // Word-granular address match per entry; byte enables deliberately ignored
  // so any overlap with the word conservatively stalls the load.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit[gi] = valid_reg[gi] && (addr_mem[gi][31:2] == load_address[31:2]);
  end

  assign load_hazard = load_check && (|hit);

  // Next-state for pointers, occupancy count and per-entry valid bits.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    valid_next = valid_reg;
    if (pop) begin
      head_next = head_reg + PTR_W'(1);
    end
    if (push) begin
      tail_next = tail_reg + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    // Push and pop never target the same slot: that needs empty or full,
    // and those states exclude a pop or a push respectively.
    for (int i = 0; i < DEPTH; i++) begin
      if (pop && (head_reg == PTR_W'(i))) begin
        valid_next[i] = 1'b0;
      end
      if (push && (tail_reg == PTR_W'(i))) begin
        valid_next[i] = 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
      resp_reg  <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      resp_reg  <= accept;
    end
  end

  // Capture the accepted store into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= mem_address;
      be_mem[tail_reg]   <= mem_byte_enable;
      data_mem[tail_reg] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven vectors, directed corner sequences and a
// randomized run, all cross-checked every cycle against a queue model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic        drain_valid;
  logic [31:0] drain_address;
  logic [2:0]  drain_sel;
  logic [1:0]  drain_align;
  logic [3:0]  drain_byte_enable;
  logic [31:0] drain_data;
  logic        drain_ack;
  logic        load_check;
  logic [31:0] load_address;
  logic        load_hazard;
  logic        empty;
  logic        full;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .mem_byte_enable   (mem_byte_enable),
    .mem_resp          (mem_resp),
    .drain_valid       (drain_valid),
    .drain_address     (drain_address),
    .drain_sel         (drain_sel),
    .drain_align       (drain_align),
    .drain_byte_enable (drain_byte_enable),
    .drain_data        (drain_data),
    .drain_ack         (drain_ack),
    .load_check        (load_check),
    .load_address      (load_address),
    .load_hazard       (load_hazard),
    .empty             (empty),
    .full              (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: an ordered list of pending stores plus the ack flag.
  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  logic resp_m;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        ack;
    logic        lc;
    logic [31:0] la;
    logic        e_resp;
    logic        e_dv;
    logic [31:0] e_daddr;
    logic [2:0]  e_sel;
    logic [1:0]  e_align;
    logic [3:0]  e_be;
    logic [31:0] e_data;
    logic        e_haz;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t vec [15];

  function automatic vec_t mk(
    input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
    input logic ack, input logic lc, input logic [31:0] la,
    input logic e_resp, input logic e_dv, input logic [31:0] e_daddr,
    input logic [2:0] e_sel, input logic [1:0] e_align, input logic [3:0] e_be,
    input logic [31:0] e_data, input logic e_haz, input logic e_empty, input logic e_full);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.be = be; v.ack = ack; v.lc = lc; v.la = la;
    v.e_resp = e_resp; v.e_dv = e_dv; v.e_daddr = e_daddr; v.e_sel = e_sel;
    v.e_align = e_align; v.e_be = e_be; v.e_data = e_data; v.e_haz = e_haz;
    v.e_empty = e_empty; v.e_full = e_full;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, let combinational outputs settle, compare against the model.
  task automatic drive_check(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic ack, input logic lc,
                             input logic [31:0] la);
    logic exp_haz;
    mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_enable = be;
    drain_ack = ack; load_check = lc; load_address = la;
    #1;
    exp_haz = 1'b0;
    foreach (q[i]) if (q[i].a[31:2] == la[31:2]) exp_haz = lc;
    chk("m_resp", mem_resp, resp_m);
    chk("m_dvalid", drain_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_daddr", drain_address, {q[0].a[31:5], 5'b0});
      chk("m_dsel", drain_sel, q[0].a[4:2]);
      chk("m_dalign", drain_align, q[0].a[1:0]);
      chk("m_dbe", drain_byte_enable, q[0].be);
      chk("m_ddata", drain_data, q[0].d);
    end
    chk("m_empty", empty, q.size() == 0);
    chk("m_full", full, q.size() == DEPTH);
    chk("m_hazard", load_hazard, exp_haz);
  endtask

  // Update the model with the applied inputs and step across the clock edge.
  task automatic advance();
    logic acc;
    ent_t e;
    acc = mem_write && !resp_m && (q.size() < DEPTH);
    if (q.size() != 0 && drain_ack) begin
      $display("pop  addr=%h be=%h data=%h", q[0].a, q[0].be, q[0].d);
      void'(q.pop_front());
    end
    if (acc) begin
      if (mem_byte_enable != 4'b0000) begin
        e.a = mem_address; e.be = mem_byte_enable; e.d = mem_wdata;
        q.push_back(e);
        $display("push addr=%h be=%h data=%h", e.a, e.be, e.d);
      end else begin
        $display("ack  addr=%h be=0 (not queued)", mem_address);
      end
    end
    resp_m = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic ack, input logic lc,
                       input logic [31:0] la);
    drive_check(wr, a, d, be, ack, lc, la);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_write = 0; mem_address = 0; mem_wdata = 0; mem_byte_enable = 0;
    drain_ack = 0; load_check = 0; load_address = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    resp_m = 1'b0;
  endtask

  // CPU-style store: hold the request until the acknowledge is seen.
  task automatic store_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      cycle(1'b1, a, d, be, 1'b0, 1'b0, 32'h0);
      got = mem_resp;
    end
    chk("store_ack_timeout", got, 1'b1);
  endtask

  initial begin
    logic [31:0] seq [8];
    rst_n = 1'b1;
    do_reset();

    // Reset state.
    chk("reset_resp", mem_resp, 1'b0);
    chk("reset_dvalid", drain_valid, 1'b0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_full", full, 1'b0);

    // Table of single-cycle vectors; each row's expectations hold before its edge.
    //          wr  addr          data          be      ack  lc   load_addr
    //          resp dv daddr     sel   align be      data          haz  empty full
    vec[0]  = mk(1, 32'h0000_1044, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0,
                 0, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
    vec[1]  = mk(1, 32'h0000_1044, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0,
                 1, 1, 32'h0000_1040, 3'd1, 2'd0, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
    vec[2]  = mk(0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0,
                 0, 1, 32'h0000_1040, 3'd1, 2'd0, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
    vec[3]  = mk(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0,
                 0, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
    vec[4]  = mk(1, 32'h0000_2008, 32'h0000_00AA, 4'h1, 0, 1, 32'h0000_2008,
                 0, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
    vec[5]  = mk(1, 32'h0000_2008, 32'h0000_00AA, 4'h1, 0, 1, 32'h0000_200B,
                 1, 1, 32'h0000_2000, 3'd2, 2'd0, 4'h1, 32'h0000_00AA, 1, 0, 0);
    vec[6]  = mk(0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0000_200C,
                 0, 1, 32'h0000_2000, 3'd2, 2'd0, 4'h1, 32'h0000_00AA, 0, 0, 0);
    vec[7]  = mk(0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h0000_200B,
                 0, 1, 32'h0000_2000, 3'd2, 2'd0, 4'h1, 32'h0000_00AA, 1, 0, 0);
    vec[8]  = mk(1, 32'h0000_3000, 32'h1111_1111, 4'h0, 0, 1, 32'h0000_200B,
                 0, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
    vec[9]  = mk(1, 32'h0000_3000, 32'h1111_1111, 4'h0, 0, 0, 32'h0,
                 1, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
    vec[10] = mk(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0,
                 0, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
    vec[11] = mk(1, 32'h0000_3017, 32'h1234_5678, 4'h8, 0, 0, 32'h0,
                 0, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);
    vec[12] = mk(1, 32'h0000_3017, 32'h1234_5678, 4'h8, 0, 1, 32'h0000_3014,
                 1, 1, 32'h0000_3000, 3'd5, 2'd3, 4'h8, 32'h1234_5678, 1, 0, 0);
    vec[13] = mk(0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0,
                 0, 1, 32'h0000_3000, 3'd5, 2'd3, 4'h8, 32'h1234_5678, 0, 0, 0);
    vec[14] = mk(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0,
                 0, 0, 32'h0, 3'd0, 2'd0, 4'h0, 32'h0, 0, 1, 0);

    for (int i = 0; i < 15; i++) begin
      drive_check(vec[i].wr, vec[i].a, vec[i].d, vec[i].be, vec[i].ack, vec[i].lc, vec[i].la);
      $display("vector %0d wr=%b addr=%h ack=%b lc=%b", i, vec[i].wr, vec[i].a, vec[i].ack, vec[i].lc);
      chk("t_resp", mem_resp, vec[i].e_resp);
      chk("t_dvalid", drain_valid, vec[i].e_dv);
      if (vec[i].e_dv) begin
        chk("t_daddr", drain_address, vec[i].e_daddr);
        chk("t_dsel", drain_sel, vec[i].e_sel);
        chk("t_dalign", drain_align, vec[i].e_align);
        chk("t_dbe", drain_byte_enable, vec[i].e_be);
        chk("t_ddata", drain_data, vec[i].e_data);
      end
      chk("t_hazard", load_hazard, vec[i].e_haz);
      chk("t_empty", empty, vec[i].e_empty);
      chk("t_full", full, vec[i].e_full);
      advance();
    end

    // Fill to DEPTH, then a fifth store must wait for a drain.
    for (int k = 1; k <= 4; k++) store_op(32'h0000_4000 + 32'(4 * k), 32'(k), 4'hF);
    chk("fill_full", full, 1'b1);
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, 32'h0000_4014, 32'd5, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("full_no_resp", mem_resp, 1'b0);
    end
    chk("drain_first", drain_data, 32'd1);
    cycle(1'b1, 32'h0000_4014, 32'd5, 4'hF, 1'b1, 1'b0, 32'h0);
    chk("full_pop_blocks_push", mem_resp, 1'b0);
    cycle(1'b1, 32'h0000_4014, 32'd5, 4'hF, 1'b0, 1'b0, 32'h0);
    chk("fifth_accepted", mem_resp, 1'b1);
    for (int k = 2; k <= 5; k++) begin
      chk("drain_order", drain_data, 32'(k));
      cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    end
    chk("drained_empty", empty, 1'b1);

    // Push and pop together at count 2, wrapping the pointers several times.
    seq[0] = 32'h10; seq[1] = 32'h11;
    for (int j = 0; j < 6; j++) seq[j + 2] = 32'h20 + 32'(j);
    store_op(32'h0000_7000, seq[0], 4'hF);
    store_op(32'h0000_7004, seq[1], 4'hF);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, 32'h0000_7100 + 32'(4 * j), seq[j + 2], 4'hF, 1'b1, 1'b0, 32'h0);
      chk("pp_head", drain_data, seq[j + 1]);
      chk("pp_not_full", full, 1'b0);
      chk("pp_not_empty", empty, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    end
    chk("pp_tail0", drain_data, seq[6]);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    chk("pp_tail1", drain_data, seq[7]);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    chk("pp_empty", empty, 1'b1);

    // Reset with three stores pending and a new store arriving at the same edge.
    store_op(32'h0000_5000, 32'hA0, 4'hF);
    store_op(32'h0000_5004, 32'hA1, 4'hF);
    store_op(32'h0000_5008, 32'hA2, 4'hF);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    mem_write = 1'b1; mem_address = 32'h0000_500C; mem_wdata = 32'hA3;
    mem_byte_enable = 4'hF; drain_ack = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; mem_write = 1'b0; drain_ack = 1'b0;
    q.delete();
    resp_m = 1'b0;
    $display("reset with 3 pending stores");
    chk("rst_resp", mem_resp, 1'b0);
    chk("rst_dvalid", drain_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_5000);
    chk("rst_no_hazard_after", load_hazard, 1'b0);

    // Randomized traffic over a narrow address window to provoke hazards.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra, rla;
      ra  = 32'h0000_6000 + 32'($urandom_range(0, 31));
      rla = 32'h0000_6000 + 32'($urandom_range(0, 31));
      cycle($urandom_range(0, 3) != 0, ra, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rla);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
